// File: rtl/tracer_pipe.sv
// tracer_pipe: DDA ray-caster emitting one wall record per screen column,
// framed by blank margin records, into the trace buffer write port.
module tracer_pipe #(
   parameter int QM        = 6,
   parameter int QN        = 10,
   parameter int MAP_BITS  = 4,
   parameter int COL_BITS  = 9,
   parameter int LMARGIN   = 64,
   parameter int RMARGIN   = 64,
   parameter int MAX_STEPS = 32,
   parameter int HMAX      = 240,
   localparam int W        = QM + QN,
   localparam int CW       = $clog2(LMARGIN + (1 << COL_BITS) + RMARGIN)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [W-1:0]        player_x,
   input  logic [W-1:0]        player_y,
   input  logic [W-1:0]        facing_x,
   input  logic [W-1:0]        facing_y,
   input  logic [W-1:0]        vplane_x,
   input  logic [W-1:0]        vplane_y,
   output logic                busy,
   output logic                done,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [CW-1:0]       wr_col,
   output logic                wr_side,
   output logic [1:0]          wr_val,
   output logic [7:0]          wr_height,
   output logic [MAP_BITS-1:0] map_col,
   output logic [MAP_BITS-1:0] map_row,
   input  logic [1:0]          map_val
);

   localparam int NTR = 1 << COL_BITS;
   localparam int SW  = $clog2(MAX_STEPS + 1);
   localparam int DW  = 2 * QN + W + 1;
   localparam int PW  = W + QN + 1;
   localparam int MW  = MAP_BITS + 1;
   localparam logic [W-1:0]  MAXP  = {1'b0, {(W-1){1'b1}}};
   localparam logic [CW-1:0] LASTL = CW'(LMARGIN - 1);
   localparam logic [CW-1:0] LASTT = CW'(LMARGIN + NTR - 1);
   localparam logic [CW-1:0] LASTC = CW'(LMARGIN + NTR + RMARGIN - 1);

   typedef enum logic [3:0] {
      IDLE, LCLEAR, INIT, STEP, CHECK, HIT, EMIT, RCLEAR, DONE
   } stateT;

   stateT state;

   logic [QN-1:0]       fracX, fracY;
   logic [MAP_BITS-1:0] cellX, cellY;
   logic [W-1:0]        rayX, rayY, incX, incY;
   logic [W-1:0]        sdX, sdY, trX, trY;
   logic [MW-1:0]       mapX, mapY;
   logic [SW-1:0]       steps;
   logic                oob;

   function automatic logic [W-1:0] absVal(input logic [W-1:0] v);
      return v[W-1] ? W'(-v) : v;
   endfunction

   // Saturates to the largest positive value so a zero ray axis never wins.
   function automatic logic [W-1:0] recip(input logic [W-1:0] m);
      logic [DW-1:0] q;
      if (m == '0)
         return MAXP;
      q = (DW'(1) << (2 * QN)) / DW'(m);
      return (q > DW'(MAXP)) ? MAXP : W'(q);
   endfunction

   logic          posX, posY;
   logic [W-1:0]  wallDist, recipIn, recipX, recipY;
   logic [QN:0]   partX, partY;
   logic [PW-1:0] prodX, prodY;
   logic [W:0]    sumX, sumY;
   logic [MW-1:0] nextX, nextY;
   logic [7:0]    hRaw, height;

   always_comb begin
      posX     = !rayX[W-1] && (rayX != '0);
      posY     = !rayY[W-1] && (rayY != '0);
      wallDist = wr_side ? trY - sdY : trX - sdX;
      recipIn  = (state == HIT) ? wallDist : absVal(rayX);
      recipX   = recip(recipIn);
      recipY   = recip(absVal(rayY));
      partX    = posX ? (QN+1)'(1 << QN) - {1'b0, fracX}
                      : {1'b0, fracX};
      partY    = posY ? (QN+1)'(1 << QN) - {1'b0, fracY}
                      : {1'b0, fracY};
      prodX    = PW'(recipX) * PW'(partX);
      prodY    = PW'(recipY) * PW'(partY);
      sumX     = {1'b0, trX} + {1'b0, sdX};
      sumY     = {1'b0, trY} + {1'b0, sdY};
      nextX    = posX ? mapX + MW'(1) : mapX - MW'(1);
      nextY    = posY ? mapY + MW'(1) : mapY - MW'(1);
      hRaw     = (recipX[W-1:QN] != '0) ? 8'hFF : recipX[QN-1 -: 8];
      height   = (hRaw > 8'(HMAX)) ? 8'(HMAX) : hRaw;
   end

   logic unusedPlayer;
   assign unusedPlayer = ^{player_x[W-1:QN+MAP_BITS],
                           player_y[W-1:QN+MAP_BITS]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_col    <= '0;
         wr_side   <= 1'b0;
         wr_val    <= '0;
         wr_height <= '0;
         map_col   <= '0;
         map_row   <= '0;
         fracX     <= '0;
         fracY     <= '0;
         cellX     <= '0;
         cellY     <= '0;
         rayX      <= '0;
         rayY      <= '0;
         incX      <= '0;
         incY      <= '0;
         sdX       <= '0;
         sdY       <= '0;
         trX       <= '0;
         trY       <= '0;
         mapX      <= '0;
         mapY      <= '0;
         steps     <= '0;
         oob       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) begin
               fracX     <= player_x[QN-1:0];
               fracY     <= player_y[QN-1:0];
               cellX     <= player_x[QN +: MAP_BITS];
               cellY     <= player_y[QN +: MAP_BITS];
               rayX      <= facing_x - vplane_x;
               rayY      <= facing_y - vplane_y;
               incX      <= $signed(vplane_x) >>> (COL_BITS - 1);
               incY      <= $signed(vplane_y) >>> (COL_BITS - 1);
               busy      <= 1'b1;
               wr_col    <= '0;
               wr_side   <= 1'b0;
               wr_val    <= '0;
               wr_height <= '0;
               if (LMARGIN > 0) begin
                  wr_valid <= 1'b1;
                  state    <= LCLEAR;
               end else begin
                  state <= INIT;
               end
            end
            LCLEAR: if (wr_ready) begin
               wr_col <= wr_col + CW'(1);
               if (wr_col == LASTL) begin
                  wr_valid <= 1'b0;
                  state    <= INIT;
               end
            end
            INIT: begin
               map_col <= cellX;
               map_row <= cellY;
               mapX    <= {1'b0, cellX};
               mapY    <= {1'b0, cellY};
               sdX     <= recipX;
               sdY     <= recipY;
               trX     <= W'(prodX >> QN);
               trY     <= W'(prodY >> QN);
               steps   <= '0;
               state   <= STEP;
            end
            STEP: begin
               if (trX < trY) begin
                  trX     <= sumX[W] ? '1 : sumX[W-1:0];
                  mapX    <= nextX;
                  wr_side <= 1'b0;
                  oob     <= nextX[MAP_BITS];
                  if (!nextX[MAP_BITS])
                     map_col <= nextX[MAP_BITS-1:0];
               end else begin
                  trY     <= sumY[W] ? '1 : sumY[W-1:0];
                  mapY    <= nextY;
                  wr_side <= 1'b1;
                  oob     <= nextY[MAP_BITS];
                  if (!nextY[MAP_BITS])
                     map_row <= nextY[MAP_BITS-1:0];
               end
               steps <= steps + SW'(1);
               state <= CHECK;
            end
            CHECK: begin
               if (oob || (map_val == 2'd0 && steps == SW'(MAX_STEPS))) begin
                  wr_val    <= '0;
                  wr_height <= '0;
                  wr_valid  <= 1'b1;
                  state     <= EMIT;
               end else if (map_val != 2'd0) begin
                  wr_val <= map_val;
                  state  <= HIT;
               end else begin
                  state <= STEP;
               end
            end
            HIT: begin
               wr_height <= height;
               wr_valid  <= 1'b1;
               state     <= EMIT;
            end
            EMIT: if (wr_ready) begin
               if (wr_col != LASTT) begin
                  wr_valid <= 1'b0;
                  wr_col   <= wr_col + CW'(1);
                  rayX     <= rayX + incX;
                  rayY     <= rayY + incY;
                  state    <= INIT;
               end else if (RMARGIN > 0) begin
                  wr_col    <= wr_col + CW'(1);
                  wr_side   <= 1'b0;
                  wr_val    <= '0;
                  wr_height <= '0;
                  state     <= RCLEAR;
               end else begin
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            RCLEAR: if (wr_ready) begin
               if (wr_col == LASTC) begin
                  wr_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  wr_col <= wr_col + CW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tracer_pipe.sv
// tb_tracer_pipe: frame-level checks of tracer_pipe against a
// behavioural DDA model with directed and random maps.
module tb_tracer_pipe;

   localparam int NREC = 640;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] player_x = '0, player_y = '0;
   logic [15:0] facing_x = '0, facing_y = '0;
   logic [15:0] vplane_x = '0, vplane_y = '0;
   logic        busy, done, wr_valid, wr_ready, wr_side;
   logic [9:0]  wr_col;
   logic [1:0]  wr_val;
   logic [7:0]  wr_height;
   logic [3:0]  map_col, map_row;
   logic [1:0]  map_val;

   logic [1:0]  mapMem [16][16];

   int nCmp = 0;
   int nBad = 0;
   int gotQ[$];
   int doneCnt = 0;
   int stallCol = -1;
   bit stallUsed = 1'b0;
   int stallLeft = 0;
   bit randReady = 1'b0;
   bit holdPrev = 1'b0;
   int holdRec = 0;
   int gPx, gPy, gFx, gFy, gVx, gVy;

   always #5 clk = ~clk;

   assign map_val = mapMem[map_row][map_col];

   tracer_pipe dut (
      .clk(clk), .reset(reset), .start(start),
      .player_x(player_x), .player_y(player_y),
      .facing_x(facing_x), .facing_y(facing_y),
      .vplane_x(vplane_x), .vplane_y(vplane_y),
      .busy(busy), .done(done),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_col(wr_col), .wr_side(wr_side),
      .wr_val(wr_val), .wr_height(wr_height),
      .map_col(map_col), .map_row(map_row), .map_val(map_val)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int s16(input int v);
      int t;
      t = v & 32'hFFFF;
      return (t >= 32768) ? t - 65536 : t;
   endfunction

   function automatic int rcp(input int m);
      int q;
      if (m == 0) return 32767;
      q = (1 << 20) / m;
      return (q > 32767) ? 32767 : q;
   endfunction

   // Reference: record k of a frame as col<<11 | side<<10 | val<<8 | height.
   function automatic int modelRec(input int col);
      int i, rx, ry, sdx, sdy, tx, ty, mx, my, sx, sy;
      int side, val, h, fr;
      bit fin;
      if (col < 64 || col >= 576) return col << 11;
      i   = col - 64;
      rx  = s16(gFx - gVx + i * (gVx >>> 8));
      ry  = s16(gFy - gVy + i * (gVy >>> 8));
      sdx = rcp(rx < 0 ? -rx : rx);
      sdy = rcp(ry < 0 ? -ry : ry);
      fr  = gPx & 1023;
      tx  = (sdx * (rx > 0 ? 1024 - fr : fr)) >> 10;
      fr  = gPy & 1023;
      ty  = (sdy * (ry > 0 ? 1024 - fr : fr)) >> 10;
      mx  = (gPx >> 10) & 15;
      my  = (gPy >> 10) & 15;
      sx  = rx > 0 ? 1 : -1;
      sy  = ry > 0 ? 1 : -1;
      side = 0; val = 0; h = 0; fin = 0;
      for (int n = 1; n <= 32 && !fin; n++) begin
         if (tx < ty) begin
            tx = (tx + sdx > 65535) ? 65535 : tx + sdx;
            mx += sx;
            side = 0;
         end else begin
            ty = (ty + sdy > 65535) ? 65535 : ty + sdy;
            my += sy;
            side = 1;
         end
         if (mx < 0 || mx > 15 || my < 0 || my > 15) begin
            fin = 1;
         end else if (mapMem[my][mx] != 0) begin
            val = int'(mapMem[my][mx]);
            h = rcp((side ? ty - sdy : tx - sdx) & 65535);
            h = (h >= 1024) ? 255 : (h >> 2) & 255;
            if (h > 240) h = 240;
            fin = 1;
         end
      end
      return (col << 11) | (side << 10) | (val << 8) | h;
   endfunction

   always @(posedge clk) begin
      #1;
      if (stallCol >= 0 && !stallUsed && wr_valid && int'(wr_col) == stallCol) begin
         stallLeft = 10;
         stallUsed = 1'b1;
      end
      if (stallLeft > 0) begin
         wr_ready = 1'b0;
         stallLeft--;
      end else begin
         wr_ready = randReady ? ($urandom_range(3) != 0) : 1'b1;
      end
   end

   always @(negedge clk) begin
      int rec;
      rec = (int'(wr_col) << 11) | (int'(wr_side) << 10)
          | (int'(wr_val) << 8) | int'(wr_height);
      if (reset) begin
         holdPrev = 1'b0;
      end else begin
         if (holdPrev)
            chk("hold", {wr_valid, 31'(rec)}, {1'b1, 31'(holdRec)});
         holdPrev = wr_valid && !wr_ready;
         holdRec  = rec;
         if (wr_valid && wr_ready) gotQ.push_back(rec);
         if (done) doneCnt++;
      end
   end

   task automatic borderMap(input int interiorDen, input int bval);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            if (r == 0 || r == 15 || c == 0 || c == 15)
               mapMem[r][c] = (bval > 0) ? 2'(bval) : 2'($urandom_range(3, 1));
            else if (interiorDen > 0 && $urandom_range(interiorDen - 1) == 0)
               mapMem[r][c] = 2'($urandom_range(3, 1));
            else
               mapMem[r][c] = 2'd0;
   endtask

   task automatic launch(input int px, py, fx, fy, vx, vy);
      gPx = px; gPy = py; gFx = fx; gFy = fy; gVx = vx; gVy = vy;
      gotQ.delete();
      doneCnt = 0;
      @(posedge clk); #1;
      player_x = 16'(px); player_y = 16'(py);
      facing_x = 16'(fx); facing_y = 16'(fy);
      vplane_x = 16'(vx); vplane_y = 16'(vy);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic runFrame(input string name, input int px, py, fx, fy,
                           input int vx, vy, input int stCol, input bit rr,
                           input bit poke);
      bit seen;
      stallCol  = stCol;
      stallUsed = 1'b0;
      randReady = rr;
      launch(px, py, fx, fy, vx, vy);
      chk({name, "_busy"}, 32'(busy), 32'd1);
      seen = 1'b0;
      for (int cyc = 0; cyc < 30000 && !seen; cyc++) begin
         @(posedge clk); #1;
         if (poke && cyc == 1000) begin
            player_x = 16'd0; facing_x = 16'd0; start = 1'b1;
         end else if (start) begin
            start = 1'b0; player_x = 16'(px); facing_x = 16'(fx);
         end
         if (done) begin
            seen = 1'b1;
            chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
            if (poke) start = 1'b1;
         end
      end
      chk({name, "_done_seen"}, 32'(seen), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_busy_idle"}, 32'(busy), 32'd0);
      chk({name, "_done_cnt"}, 32'(doneCnt), 32'd1);
      chk({name, "_count"}, 32'(gotQ.size()), 32'(NREC));
      for (int k = 0; k < gotQ.size() && k < NREC; k++)
         chk($sformatf("%s_rec%0d", name, k), 32'(gotQ[k]), 32'(modelRec(k)));
      stallCol  = -1;
      randReady = 1'b0;
   endtask

   task automatic randFrame(input string name, input bit rr);
      int fx;
      borderMap(4, 0);
      fx = int'($urandom_range(2048, 512));
      if ($urandom_range(1) == 1) fx = -fx;
      runFrame(name,
               int'($urandom_range(15359, 1024)), int'($urandom_range(15359, 1024)),
               fx, int'($urandom_range(1536)) - 768,
               int'($urandom_range(1024)) - 512, int'($urandom_range(1024)) - 512,
               -1, rr, 1'b0);
   endtask

   initial begin
      int hsum;
      bit reached;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state",
          {busy, done, wr_valid, wr_side, wr_val, wr_height, wr_col, map_col, map_row},
          32'd0);
      reset = 1'b0;

      borderMap(0, 2);
      runFrame("centre", 8704, 8704, 1024, 0, 0, 512, 100, 1'b0, 1'b1);
      chk("centre_c320", 32'(gotQ.size() > 320 ? gotQ[320] : -1),
          32'(320 * 2048 + 2 * 256 + 39));
      chk("centre_stalled", 32'(stallUsed), 32'd1);

      runFrame("near", 15104, 8704, 1024, 0, 0, 512, -1, 1'b0, 1'b0);
      chk("near_c320", 32'(gotQ.size() > 320 ? gotQ[320] : -1),
          32'(320 * 2048 + 2 * 256 + 240));

      borderMap(0, 2);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            mapMem[r][c] = 2'd0;
      runFrame("empty", 14848, 14848, 1024, 0, 0, 512, -1, 1'b0, 1'b0);
      hsum = 0;
      foreach (gotQ[k]) hsum += gotQ[k] & 32'h3FF;
      chk("empty_valheight", 32'(hsum), 32'd0);

      randFrame("rand0", 1'b1);
      randFrame("rand1", 1'b0);

      borderMap(0, 3);
      randReady = 1'b0;
      launch(8704, 8704, 1024, 0, 0, 512);
      reached = 1'b0;
      for (int cyc = 0; cyc < 20000 && !reached; cyc++) begin
         @(posedge clk); #1;
         reached = (gotQ.size() > 300);
      end
      chk("mid_reached", 32'(reached), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_valid", 32'(wr_valid), 32'd0);
      chk("mid_col", 32'(wr_col), 32'd0);
      reset = 1'b0;
      randFrame("after_reset", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
